rc5_engine_ctrl: RTL and testbench
==================================

Name: rc5_engine_ctrl

Overview:
- Top-level sequencer for the RC5 encryption engine.
- Owns the shared dual-port S-table RAM:
  - grants it to the key-schedule unit during key expansion;
  - grants it to the cipher core during block encryption.
- Accepts plaintext blocks on a valid/ready handshake, runs the cipher core (reset, start, wait for done), and returns ciphertext on a valid/ready output handshake.
- Provides watchdog timeouts on both sub-units and a completed-block counter.

Parameters:
W, 32, word width of A/B and S-table entries
R, 12, RC5 round count
T_LENGTH, $clog2(2*(R+1)) (5 at default), S-table address width
KS_TIMEOUT, 1023, max cycles allowed in KS_RUN before error
CPH_TIMEOUT, 255, max cycles allowed in CPH_RUN before error

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
iKey_start  in  1  request (re)key expansion
oKs_start  out  1  one-cycle start pulse to key-schedule unit
iKs_done  in  1  key-schedule finished (level)
iKs_we  in  1  key-schedule RAM write enable
iKs_addr1  in  T_LENGTH  key-schedule RAM port 1 address (write/read)
iKs_addr2  in  T_LENGTH  key-schedule RAM port 2 address (read)
iKs_wdata  in  W  key-schedule write data
iCph_addr1  in  T_LENGTH  cipher core RAM port 1 address
iCph_addr2  in  T_LENGTH  cipher core RAM port 2 address
oRam_we  out  1  RAM write enable (port 1)
oRam_addr1  out  T_LENGTH  RAM port 1 address
oRam_addr2  out  T_LENGTH  RAM port 2 address
oRam_wdata  out  W  RAM write data
oCph_rst  out  1  one-cycle synchronous reset pulse to cipher core
oCph_start  out  1  one-cycle start pulse to cipher core
oCph_A, oCph_B  out  W each  plaintext presented to core, stable from CPH_RST to CPH_RUN exit
iCph_done  in  1  core done (level, sticky until core reset)
iCph_A, iCph_B  in  W each  core ciphertext
iIn_valid  in  1  plaintext valid
oIn_ready  out  1  plaintext accept
iIn_A, iIn_B  in  W each  plaintext words
oOut_valid  out  1  ciphertext valid
iOut_ready  in  1  downstream accept
oOut_A, oOut_B  out  W each  ciphertext words
oKey_valid  out  1  S-table holds a complete expanded key
oErr  out  1  sticky timeout flag
oBlk_count  out  16  completed blocks, wraps 0xFFFF -> 0x0000

Behaviour:
- Reset values: state IDLE; every output 0, including oOut_A/B, oCph_A/B, oBlk_count, oErr; rekey-pending flag 0; watchdog counter 0.
- States: IDLE, KS_START, KS_RUN, READY, CPH_RST, CPH_START, CPH_RUN, OUT_HOLD.
- IDLE: iKey_start -> KS_START; otherwise stay. oIn_ready=0.
- KS_START: oKs_start=1 for this cycle only. Clear oKey_valid, oErr and the watchdog. -> KS_RUN.
- KS_RUN: watchdog increments each cycle.
  - iKs_done=1 -> READY, oKey_valid<=1.
  - Otherwise, if watchdog reaches KS_TIMEOUT -> IDLE, oErr<=1, oKey_valid stays 0.
- READY:
  - oIn_ready = (state==READY) & ~pending & ~iKey_start (combinational).
  - iKey_start or pending -> KS_START, clear pending. Rekey wins over a simultaneous iIn_valid; that block is not accepted.
  - Else iIn_valid & oIn_ready: capture iIn_A/B into oCph_A/B -> CPH_RST.
- CPH_RST: oCph_rst=1 for one cycle -> CPH_START.
- CPH_START: oCph_start=1 for one cycle; clear watchdog -> CPH_RUN.
- CPH_RUN:
  - iCph_done sampled high: oOut_A/B <= iCph_A/B, oOut_valid<=1 -> OUT_HOLD.
  - iCph_done is ignored in CPH_RST and CPH_START.
  - Watchdog reaching CPH_TIMEOUT -> IDLE, oErr<=1, oKey_valid<=0, no output produced.
- OUT_HOLD: oOut_valid and data held until iOut_ready. Then oOut_valid<=0, oBlk_count+1 -> READY.
- Minimum accept-to-valid latency: 4 cycles plus core processing time.
- iKey_start in CPH_RST..OUT_HOLD sets pending. The in-flight block still completes; the rekey is serviced on return to READY. iKey_start in KS_START/KS_RUN is ignored.
- RAM mux (combinational):
  - KS_START/KS_RUN: oRam_we=iKs_we, addr1=iKs_addr1, addr2=iKs_addr2, wdata=iKs_wdata.
  - All other states: oRam_we=0, addr1=iCph_addr1, addr2=iCph_addr2, wdata=0.
  - oRam_we is never 1 outside the KS states.
- Reset mid-operation: immediate return to reset values. The S-table content is not considered valid; oKey_valid=0 until the next key expansion.

Test Plan:
- Rekey then block: iKey_start pulse; iKs_done after 20 cycles -> oKs_start high exactly 1 cycle, oKey_valid=1; block A=0x00000000,B=0x00000000 accepted; core returns 0xEEDBA521/0x6D8F4B15 -> oOut matches, oBlk_count=1.
- Backpressure: iOut_ready low 10 cycles -> oOut_valid and data stable, oIn_ready=0 throughout; release -> next block accepted one cycle after return to READY.
- Simultaneous iKey_start and iIn_valid in READY -> block not accepted, KS_START entered; iKey_start during CPH_RUN -> block completes, then KS_START before the next accept.
- RAM ownership: iKs_we=1, addr1=25 in KS_RUN -> oRam_we=1, oRam_addr1=25; iKs_we=1 while in CPH_RUN -> oRam_we=0, addresses follow iCph_addr1/2.
- Timeouts: iKs_done never asserted -> oErr=1 after 1023 cycles, state IDLE; iCph_done never asserted -> oErr=1 after 255 cycles, oKey_valid=0, oOut_valid stays 0.
- Counter wrap and reset: preset oBlk_count to 0xFFFF via 65535 blocks (or force) -> next block gives 0x0000; rst asserted in CPH_RUN -> all outputs 0 next cycle.

Source files
------------

// File: rtl/rc5_engine_ctrl.sv
// RC5 engine sequencer: owns the shared S-table RAM, runs key expansion and
// per-block encryption with watchdogs, and counts completed blocks.
module rc5_engine_ctrl #(
  parameter int unsigned W           = 32,
  parameter int unsigned R           = 12,
  parameter int unsigned T_LENGTH    = $clog2(2 * (R + 1)),
  parameter int unsigned KS_TIMEOUT  = 1023,
  parameter int unsigned CPH_TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                iKey_start,
  output logic                oKs_start,
  input  logic                iKs_done,
  input  logic                iKs_we,
  input  logic [T_LENGTH-1:0] iKs_addr1,
  input  logic [T_LENGTH-1:0] iKs_addr2,
  input  logic [W-1:0]        iKs_wdata,
  input  logic [T_LENGTH-1:0] iCph_addr1,
  input  logic [T_LENGTH-1:0] iCph_addr2,
  output logic                oRam_we,
  output logic [T_LENGTH-1:0] oRam_addr1,
  output logic [T_LENGTH-1:0] oRam_addr2,
  output logic [W-1:0]        oRam_wdata,
  output logic                oCph_rst,
  output logic                oCph_start,
  output logic [W-1:0]        oCph_A,
  output logic [W-1:0]        oCph_B,
  input  logic                iCph_done,
  input  logic [W-1:0]        iCph_A,
  input  logic [W-1:0]        iCph_B,
  input  logic                iIn_valid,
  output logic                oIn_ready,
  input  logic [W-1:0]        iIn_A,
  input  logic [W-1:0]        iIn_B,
  output logic                oOut_valid,
  input  logic                iOut_ready,
  output logic [W-1:0]        oOut_A,
  output logic [W-1:0]        oOut_B,
  output logic                oKey_valid,
  output logic                oErr,
  output logic [15:0]         oBlk_count
);

  localparam int unsigned WD_MAX = (KS_TIMEOUT > CPH_TIMEOUT) ? KS_TIMEOUT : CPH_TIMEOUT;
  localparam int unsigned WD_W   = $clog2(WD_MAX + 1);
  // Last allowed run cycle: the watchdog would reach the timeout on this edge.
  localparam logic [WD_W-1:0] KS_LAST  = WD_W'(KS_TIMEOUT - 1);
  localparam logic [WD_W-1:0] CPH_LAST = WD_W'(CPH_TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle, StKsStart, StKsRun, StReady, StCphRst, StCphStart, StCphRun, StOutHold
  } state_e;

  state_e          r_state, w_state_nxt;
  logic [WD_W-1:0] r_wd, w_wd_nxt;
  logic            r_pending, w_pending_nxt;
  logic            r_key_valid, w_key_valid_nxt;
  logic            r_err, w_err_nxt;
  logic [W-1:0]    r_cph_a, w_cph_a_nxt, r_cph_b, w_cph_b_nxt;
  logic [W-1:0]    r_out_a, w_out_a_nxt, r_out_b, w_out_b_nxt;
  logic [15:0]     r_blk_count, w_blk_count_nxt;
  logic            w_ks_owner;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_wd        <= '0;
      r_pending   <= 1'b0;
      r_key_valid <= 1'b0;
      r_err       <= 1'b0;
      r_cph_a     <= '0;
      r_cph_b     <= '0;
      r_out_a     <= '0;
      r_out_b     <= '0;
      r_blk_count <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_wd        <= w_wd_nxt;
      r_pending   <= w_pending_nxt;
      r_key_valid <= w_key_valid_nxt;
      r_err       <= w_err_nxt;
      r_cph_a     <= w_cph_a_nxt;
      r_cph_b     <= w_cph_b_nxt;
      r_out_a     <= w_out_a_nxt;
      r_out_b     <= w_out_b_nxt;
      r_blk_count <= w_blk_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_wd_nxt        = r_wd;
    w_pending_nxt   = r_pending;
    w_key_valid_nxt = r_key_valid;
    w_err_nxt       = r_err;
    w_cph_a_nxt     = r_cph_a;
    w_cph_b_nxt     = r_cph_b;
    w_out_a_nxt     = r_out_a;
    w_out_b_nxt     = r_out_b;
    w_blk_count_nxt = r_blk_count;
    unique case (r_state)
      StIdle: begin
        if (iKey_start) w_state_nxt = StKsStart;
      end
      StKsStart: begin
        w_key_valid_nxt = 1'b0;
        w_err_nxt       = 1'b0;
        w_wd_nxt        = '0;
        w_state_nxt     = StKsRun;
      end
      StKsRun: begin
        if (iKs_done) begin
          w_key_valid_nxt = 1'b1;
          w_state_nxt     = StReady;
        end else if (r_wd == KS_LAST) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = StIdle;
        end else begin
          w_wd_nxt = r_wd + 1'b1;
        end
      end
      StReady: begin
        // A rekey request takes priority over a block offered in the same cycle.
        if (iKey_start || r_pending) begin
          w_pending_nxt = 1'b0;
          w_state_nxt   = StKsStart;
        end else if (iIn_valid) begin
          w_cph_a_nxt = iIn_A;
          w_cph_b_nxt = iIn_B;
          w_state_nxt = StCphRst;
        end
      end
      StCphRst: begin
        w_pending_nxt = r_pending | iKey_start;
        w_state_nxt   = StCphStart;
      end
      StCphStart: begin
        w_pending_nxt = r_pending | iKey_start;
        w_wd_nxt      = '0;
        w_state_nxt   = StCphRun;
      end
      StCphRun: begin
        w_pending_nxt = r_pending | iKey_start;
        if (iCph_done) begin
          w_out_a_nxt = iCph_A;
          w_out_b_nxt = iCph_B;
          w_state_nxt = StOutHold;
        end else if (r_wd == CPH_LAST) begin
          // Key state is untrusted after a hung core; a fresh rekey is required.
          w_err_nxt       = 1'b1;
          w_key_valid_nxt = 1'b0;
          w_pending_nxt   = 1'b0;
          w_state_nxt     = StIdle;
        end else begin
          w_wd_nxt = r_wd + 1'b1;
        end
      end
      StOutHold: begin
        w_pending_nxt = r_pending | iKey_start;
        if (iOut_ready) begin
          w_blk_count_nxt = r_blk_count + 16'd1;
          w_state_nxt     = StReady;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  assign w_ks_owner = (r_state == StKsStart) || (r_state == StKsRun);

  always_comb begin
    oRam_we    = 1'b0;
    oRam_addr1 = iCph_addr1;
    oRam_addr2 = iCph_addr2;
    oRam_wdata = '0;
    if (w_ks_owner) begin
      oRam_we    = iKs_we;
      oRam_addr1 = iKs_addr1;
      oRam_addr2 = iKs_addr2;
      oRam_wdata = iKs_wdata;
    end
  end

  assign oKs_start  = (r_state == StKsStart);
  assign oCph_rst   = (r_state == StCphRst);
  assign oCph_start = (r_state == StCphStart);
  assign oOut_valid = (r_state == StOutHold);
  assign oIn_ready  = (r_state == StReady) && !r_pending && !iKey_start;
  assign oCph_A     = r_cph_a;
  assign oCph_B     = r_cph_b;
  assign oOut_A     = r_out_a;
  assign oOut_B     = r_out_b;
  assign oKey_valid = r_key_valid;
  assign oErr       = r_err;
  assign oBlk_count = r_blk_count;

endmodule

// File: tb/tb_rc5_engine_ctrl.sv
// Bench for rc5_engine_ctrl: transaction-level reference model compared every
// cycle, directed scenarios with literal expectations, then a random phase.
module tb_rc5_engine_ctrl;
  localparam int W = 32;
  localparam int TL = 5;
  localparam int KS_TO = 1023;
  localparam int CPH_TO = 255;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          iKey_start = 0, iKs_done = 0, iKs_we = 0;
  logic [TL-1:0] iKs_addr1 = 0, iKs_addr2 = 0, iCph_addr1 = 0, iCph_addr2 = 0;
  logic [W-1:0]  iKs_wdata = 0, iCph_A = 0, iCph_B = 0, iIn_A = 0, iIn_B = 0;
  logic          iCph_done = 0, iIn_valid = 0, iOut_ready = 0;
  logic          oKs_start, oRam_we, oCph_rst, oCph_start, oIn_ready, oOut_valid;
  logic          oKey_valid, oErr;
  logic [TL-1:0] oRam_addr1, oRam_addr2;
  logic [W-1:0]  oRam_wdata, oCph_A, oCph_B, oOut_A, oOut_B;
  logic [15:0]   oBlk_count;

  always #5 clk = ~clk;

  rc5_engine_ctrl #(
    .W(W), .R(12), .T_LENGTH(TL), .KS_TIMEOUT(KS_TO), .CPH_TIMEOUT(CPH_TO)
  ) dut (
    .clk(clk), .rst(rst), .iKey_start(iKey_start), .oKs_start(oKs_start),
    .iKs_done(iKs_done), .iKs_we(iKs_we), .iKs_addr1(iKs_addr1), .iKs_addr2(iKs_addr2),
    .iKs_wdata(iKs_wdata), .iCph_addr1(iCph_addr1), .iCph_addr2(iCph_addr2),
    .oRam_we(oRam_we), .oRam_addr1(oRam_addr1), .oRam_addr2(oRam_addr2),
    .oRam_wdata(oRam_wdata), .oCph_rst(oCph_rst), .oCph_start(oCph_start),
    .oCph_A(oCph_A), .oCph_B(oCph_B), .iCph_done(iCph_done), .iCph_A(iCph_A),
    .iCph_B(iCph_B), .iIn_valid(iIn_valid), .oIn_ready(oIn_ready), .iIn_A(iIn_A),
    .iIn_B(iIn_B), .oOut_valid(oOut_valid), .iOut_ready(iOut_ready), .oOut_A(oOut_A),
    .oOut_B(oOut_B), .oKey_valid(oKey_valid), .oErr(oErr), .oBlk_count(oBlk_count)
  );

  int n_total = 0;
  int n_bad = 0;
  bit chk_en = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: what the engine is doing, in terms of activity ages.
  bit          m_keying, m_ready, m_inflight, m_hold, m_pend, m_kv, m_err;
  int          m_kage;  // 0: start-pulse cycle, k>=1: k-th expansion cycle
  int          m_bage;  // 0: core reset, 1: core start, k>=2: (k-1)-th run cycle
  logic [31:0] m_ca, m_cb, m_oa, m_ob;
  logic [15:0] m_cnt;

  task automatic model_step();
    if (rst) begin
      {m_keying, m_ready, m_inflight, m_hold, m_pend, m_kv, m_err} = '0;
      m_kage = 0; m_bage = 0;
      m_ca = 0; m_cb = 0; m_oa = 0; m_ob = 0; m_cnt = 0;
    end else if (m_keying) begin
      if (m_kage == 0) begin
        m_kv = 0; m_err = 0; m_kage = 1;
      end else if (iKs_done) begin
        m_keying = 0; m_ready = 1; m_kv = 1;
      end else if (m_kage == KS_TO) begin
        m_keying = 0; m_err = 1;
      end else m_kage++;
    end else if (m_ready) begin
      if (iKey_start || m_pend) begin
        m_ready = 0; m_pend = 0; m_keying = 1; m_kage = 0;
      end else if (iIn_valid) begin
        m_ready = 0; m_inflight = 1; m_bage = 0; m_ca = iIn_A; m_cb = iIn_B;
      end
    end else if (m_inflight) begin
      if (iKey_start) m_pend = 1;
      if (m_bage < 2) m_bage++;
      else if (iCph_done) begin
        m_inflight = 0; m_hold = 1; m_oa = iCph_A; m_ob = iCph_B;
      end else if (m_bage - 1 == CPH_TO) begin
        m_inflight = 0; m_err = 1; m_kv = 0; m_pend = 0;
      end else m_bage++;
    end else if (m_hold) begin
      if (iKey_start) m_pend = 1;
      if (iOut_ready) begin
        m_hold = 0; m_ready = 1; m_cnt++;
      end
    end else if (iKey_start) begin
      m_keying = 1; m_kage = 0;
    end
  endtask

  always @(posedge clk) model_step();

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ks_start", oKs_start, m_keying && m_kage == 0);
      chk("cph_rst", oCph_rst, m_inflight && m_bage == 0);
      chk("cph_start", oCph_start, m_inflight && m_bage == 1);
      chk("in_ready", oIn_ready, m_ready && !m_pend && !iKey_start);
      chk("out_valid", oOut_valid, m_hold);
      chk("out_a", oOut_A, m_oa);
      chk("out_b", oOut_B, m_ob);
      chk("cph_a", oCph_A, m_ca);
      chk("cph_b", oCph_B, m_cb);
      chk("key_valid", oKey_valid, m_kv);
      chk("err", oErr, m_err);
      chk("blk_count", oBlk_count, m_cnt);
      chk("ram_we", oRam_we, m_keying ? iKs_we : 1'b0);
      chk("ram_addr1", oRam_addr1, m_keying ? iKs_addr1 : iCph_addr1);
      chk("ram_addr2", oRam_addr2, m_keying ? iKs_addr2 : iCph_addr2);
      chk("ram_wdata", oRam_wdata, m_keying ? iKs_wdata : 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!oIn_ready && n < 200) begin
      tick();
      n++;
    end
    if (!oIn_ready) chk("wait_ready_timeout", 1'b0, 1'b1);
  endtask

  task automatic rekey(input int lat);
    iKey_start = 1; tick(); iKey_start = 0;
    tick();
    repeat (lat) tick();
    iKs_done = 1; tick(); iKs_done = 0;
  endtask

  task automatic do_block(input logic [31:0] a, b, ra, rb, input int lat, input int bp);
    wait_ready();
    iIn_valid = 1; iIn_A = a; iIn_B = b;
    tick();
    iIn_valid = 0; iIn_A = $urandom; iIn_B = $urandom;
    tick(); tick();
    repeat (lat) tick();
    iCph_A = ra; iCph_B = rb; iCph_done = 1;
    tick();
    iCph_done = 0; iOut_ready = 0;
    repeat (bp) tick();
    iOut_ready = 1; tick(); iOut_ready = 0;
  endtask

  initial begin
    int n;
    tick(); tick();
    rst = 0;
    chk_en = 1;
    chk("rst_key_valid", oKey_valid, 1'b0);
    chk("rst_blk_count", oBlk_count, 16'd0);

    // Rekey then one block of zeros.
    iKey_start = 1; tick(); iKey_start = 0;
    chk("t1_ks_pulse", oKs_start, 1'b1);
    tick();
    chk("t1_ks_pulse_end", oKs_start, 1'b0);
    iKs_we = 1; iKs_addr1 = 25; iKs_wdata = 32'hA5A5_0001; #1;
    chk("t1_ram_we", oRam_we, 1'b1);
    chk("t1_ram_addr1", oRam_addr1, 5'd25);
    repeat (19) tick();
    iKs_we = 0; iKs_done = 1; tick(); iKs_done = 0;
    chk("t1_key_valid", oKey_valid, 1'b1);
    do_block(32'h0, 32'h0, 32'hEEDBA521, 32'h6D8F4B15, 3, 0);
    chk("t1_out_a", oOut_A, 32'hEEDBA521);
    chk("t1_out_b", oOut_B, 32'h6D8F4B15);
    chk("t1_blk_count", oBlk_count, 16'd1);

    // Backpressure, then immediate next block.
    do_block(32'h1111_2222, 32'h3333_4444, 32'hCAFE_0001, 32'hBEEF_0002, 0, 10);
    chk("bp_ready_after", oIn_ready, 1'b1);
    do_block(32'h5, 32'h6, 32'h7, 32'h8, 1, 2);
    chk("bp_blk_count", oBlk_count, 16'd3);

    // Simultaneous rekey and block offer.
    iKey_start = 1; iIn_valid = 1; iIn_A = 32'hDEAD; #1;
    chk("sim_in_ready", oIn_ready, 1'b0);
    tick(); iKey_start = 0; iIn_valid = 0;
    chk("sim_ks_start", oKs_start, 1'b1);
    chk("sim_no_cph_rst", oCph_rst, 1'b0);
    tick(); repeat (3) tick();
    iKs_done = 1; tick(); iKs_done = 0;

    // Rekey during core run; RAM stays with the core.
    wait_ready();
    iIn_valid = 1; iIn_A = 32'h9; iIn_B = 32'hA; tick(); iIn_valid = 0;
    tick(); tick();
    iKs_we = 1; iCph_addr1 = 7; iCph_addr2 = 19; #1;
    chk("run_ram_we", oRam_we, 1'b0);
    chk("run_ram_addr1", oRam_addr1, 5'd7);
    chk("run_ram_addr2", oRam_addr2, 5'd19);
    iKs_we = 0;
    iKey_start = 1; tick(); iKey_start = 0;
    iCph_A = 32'h1234_5678; iCph_B = 32'h9ABC_DEF0; iCph_done = 1; tick(); iCph_done = 0;
    iOut_ready = 1; tick(); iOut_ready = 0;
    chk("pend_in_ready", oIn_ready, 1'b0);
    chk("pend_out_a", oOut_A, 32'h1234_5678);
    tick();
    chk("pend_ks_start", oKs_start, 1'b1);
    tick(); iKs_done = 1; tick(); iKs_done = 0;

    // Key-schedule watchdog: 1 start cycle + 1023 run cycles.
    iKey_start = 1; tick(); iKey_start = 0;
    n = 0;
    while (!oErr && n < 1100) begin tick(); n++; end
    chk("ks_timeout_cycles", n, 1024);
    chk("ks_timeout_kv", oKey_valid, 1'b0);
    iKs_we = 1; #1;
    chk("ks_timeout_idle_we", oRam_we, 1'b0);
    iKs_we = 0;

    // Core watchdog: reset + start + 255 run cycles.
    rekey(5);
    wait_ready();
    iIn_valid = 1; iIn_A = 32'h77; tick(); iIn_valid = 0;
    n = 0;
    while (!oErr && n < 400) begin tick(); n++; end
    chk("cph_timeout_cycles", n, 257);
    chk("cph_timeout_kv", oKey_valid, 1'b0);
    chk("cph_timeout_ovalid", oOut_valid, 1'b0);

    // Counter wrap.
    rekey(2);
    wait_ready();
    force dut.r_blk_count = 16'hFFFF;
    m_cnt = 16'hFFFF;
    tick();
    release dut.r_blk_count;
    tick();
    chk("wrap_preset", oBlk_count, 16'hFFFF);
    do_block(32'hAB, 32'hCD, 32'h1, 32'h2, 0, 0);
    chk("wrap_zero", oBlk_count, 16'h0000);
    do_block(32'hAB, 32'hCD, 32'hF00D, 32'h2, 0, 0);

    // Reset during core run.
    wait_ready();
    iIn_valid = 1; iIn_A = 32'h1234; iIn_B = 32'h5678; tick(); iIn_valid = 0;
    tick(); tick();
    rst = 1; tick(); rst = 0;
    chk("mid_rst_kv", oKey_valid, 1'b0);
    chk("mid_rst_cnt", oBlk_count, 16'd0);
    chk("mid_rst_cph_a", oCph_A, 32'd0);
    chk("mid_rst_out_a", oOut_A, 32'd0);
    chk("mid_rst_cph_start", oCph_start, 1'b0);

    // Random phase.
    for (int i = 0; i < 3000; i++) begin
      rst        = ($urandom_range(999) < 3);
      iKey_start = ($urandom_range(99) < 3);
      iKs_done   = ($urandom_range(99) < 8);
      iKs_we     = 1'($urandom);
      iKs_addr1  = TL'($urandom); iKs_addr2 = TL'($urandom);
      iCph_addr1 = TL'($urandom); iCph_addr2 = TL'($urandom);
      iKs_wdata  = $urandom;
      iCph_done  = ($urandom_range(99) < 30);
      iCph_A     = $urandom; iCph_B = $urandom;
      iIn_valid  = ($urandom_range(99) < 60);
      iIn_A      = $urandom; iIn_B = $urandom;
      iOut_ready = ($urandom_range(99) < 50);
      tick();
    end
    rst = 0;
    tick(); tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
